inst_encoder: RTL and testbench

- Encoder-side counterpart of the core's instruction decoder. Turns symbolic micro-op requests into RV32 machine words and writes them sequentially into instruction memory.
- Covers the supported subset only: add, sub, and, or, addi, andi, ori, lw, sw, beq.
- Sits between a host/bootstrap source and the instruction-memory write port.
- Contains a DEPTH-entry word FIFO so it absorbs memory stalls. It also checks legality and reports errors.

---
 rtl/inst_encoder.sv | 134 +++++++++++++
 tb/tb_inst_encoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32 subset encoder: turns micro-op requests into machine words, queues them, and writes them to sequential imem addresses.
// Latency 1 cycle from accept to imem_we. Backpressure: in_ready drops when the word FIFO is full; imem_ready stalls draining.
module inst_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   words_written,
  output logic              mem_full,
  output logic              err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CAP_C   = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);

  logic [31:0]      fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]  ww_q, ww_d;
  logic             full_q, full_d;
  logic             err_q, err_d;

  logic [31:0] enc;
  logic        legal;
  logic        imm_fits;
  logic        accept, push, pop;

  // Encoder: field layout follows the standard RV32I R/I/S/B formats.
  always_comb begin
    enc      = '0;
    legal    = 1'b1;
    imm_fits = (in_imm[12] == in_imm[11]);
    case (in_op)
      4'd0: enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      4'd1: enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      4'd2: enc = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, 7'b0110011};
      4'd3: enc = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, 7'b0110011};
      4'd4: begin
        enc   = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
        legal = imm_fits;
      end
      4'd5: begin
        enc   = {in_imm[11:0], in_rs1, 3'b111, in_rd, 7'b0010011};
        legal = imm_fits;
      end
      4'd6: begin
        enc   = {in_imm[11:0], in_rs1, 3'b110, in_rd, 7'b0010011};
        legal = imm_fits;
      end
      4'd7: begin
        enc   = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        legal = imm_fits;
      end
      4'd8: begin
        enc   = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        legal = imm_fits;
      end
      4'd9: begin
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                 in_imm[4:1], in_imm[11], 7'b1100011};
        legal = !in_imm[0];
      end
      default: legal = 1'b0;
    endcase
  end

  assign in_ready      = !rst && (cnt_q < DEPTH_C);
  assign accept        = in_valid && in_ready;
  assign push          = accept && legal;
  assign imem_we       = (cnt_q != '0) && !full_q;
  assign pop           = imem_we && imem_ready;
  assign imem_addr     = ADDR_W'(BASE_ADDR) + ww_q[ADDR_W-1:0];
  assign imem_wdata    = (cnt_q != '0) ? fifo_q[rd_ptr_q] : 32'h0;
  assign words_written = ww_q;
  assign mem_full      = full_q;
  assign err           = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ww_d     = ww_q;
    full_d   = full_q;
    err_d    = err_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      ww_d     = ww_q + 1'b1;
      if (ww_d == CAP_C) full_d = 1'b1;
    end
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
    if (accept && !legal) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ww_q     <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ww_q     <= ww_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= enc;
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized and directed bench for inst_encoder against a queue-based reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;
  logic        imem_we, imem_ready;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  words_written;
  logic        mem_full, err;

  logic        s_valid, s_in_ready, s_we, s_full, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_ww;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state for the main instance
  logic [31:0] mq[$];
  int          m_ww;
  bit          m_full, m_err;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .words_written(words_written),
    .mem_full(mem_full), .err(err)
  );

  inst_encoder #(.ADDR_W(2), .BASE_ADDR(0), .DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(s_we), .imem_ready(imem_ready), .imem_addr(s_addr),
    .imem_wdata(s_wdata), .words_written(s_ww),
    .mem_full(s_full), .err(s_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Encoding rebuilt from the ISA field positions with integer arithmetic.
  function automatic logic [31:0] ref_word(int op, int rd, int rs1, int rs2, int imm);
    int u;
    int f3;
    u = imm & 32'h1FFF;
    f3 = (op == 2 || op == 5) ? 7 : (op == 3 || op == 6) ? 6 : 0;
    if (op <= 3)
      return 32'(((op == 1 ? 32 : 0) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33);
    if (op <= 6)
      return 32'(((u & 'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13);
    if (op == 7)
      return 32'(((u & 'hFFF) << 20) + (rs1 << 15) + (2 << 12) + (rd << 7) + 'h03);
    if (op == 8)
      return 32'((((u >> 5) & 'h7F) << 25) + (rs2 << 20) + (rs1 << 15) + (2 << 12) + ((u & 31) << 7) + 'h23);
    return 32'((((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
               | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 'h63);
  endfunction

  function automatic bit ref_legal(int op, int imm);
    if (op >= 10) return 0;
    if (op >= 4 && op <= 8) return (imm >= -2048 && imm <= 2047);
    if (op == 9) return (imm % 2) == 0;
    return 1;
  endfunction

  task automatic check_state();
    chk("in_ready", in_ready, !rst && mq.size() < 4);
    chk("imem_we", imem_we, mq.size() > 0 && !m_full);
    chk("imem_addr", imem_addr, m_ww & 255);
    chk("imem_wdata", imem_wdata, mq.size() > 0 ? mq[0] : 32'h0);
    chk("words_written", words_written, m_ww);
    chk("mem_full", mem_full, m_full);
    chk("err", err, m_err);
  endtask

  // One clock edge with the currently driven inputs; model follows, then outputs are checked at negedge.
  task automatic cycle();
    bit acc, pop, lg;
    int s_imm;
    logic [31:0] w;
    s_imm = int'($signed(in_imm));
    acc = in_valid && !rst && mq.size() < 4;
    pop = !rst && mq.size() > 0 && !m_full && imem_ready;
    lg  = ref_legal(int'(in_op), s_imm);
    w   = ref_word(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), s_imm);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ww = 0; m_full = 0; m_err = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_ww++;
        if (m_ww == 256) m_full = 1;
      end
      if (acc) begin
        if (lg) mq.push_back(w);
        else m_err = 1;
      end
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic set_req(input int op, input int rd, input int rs1, input int rs2, input int imm);
    in_op = 4'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 13'(imm);
  endtask

  task automatic one_req(input int op, input int rd, input int rs1, input int rs2, input int imm);
    set_req(op, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic rand_req();
    int op, imm;
    op  = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
    imm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8191) : int'($urandom_range(0, 4095)) - 2048;
    if (op == 9 && $urandom_range(0, 3) != 0) imm = imm & ~1;
    set_req(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
  endtask

  initial begin
    int idx, n, acc_cnt, ww0;
    int bp_op[6], bp_imm[6];

    rst = 1'b1; in_valid = 1'b0; s_valid = 1'b0; imem_ready = 1'b1;
    set_req(0, 0, 0, 0, 0);
    m_ww = 0; m_full = 0; m_err = 0;
    @(negedge clk);
    cycle(); cycle();
    chk("rst_wdata", imem_wdata, 32'h0);
    rst = 1'b0;
    cycle();

    // Directed encodes with known machine words
    one_req(0, 3, 1, 2, 0);
    chk("add_word", imem_wdata, 32'h002081B3);
    chk("add_addr", imem_addr, 8'd0);
    one_req(1, 5, 6, 7, 0);
    chk("sub_word", imem_wdata, 32'h407302B3);
    chk("sub_addr", imem_addr, 8'd1);
    one_req(7, 1, 2, 0, -4);
    chk("lw_word", imem_wdata, 32'hFFC12083);
    one_req(8, 0, 2, 5, 8);
    chk("sw_word", imem_wdata, 32'h00512423);
    one_req(9, 0, 1, 2, -8);
    chk("beq_word", imem_wdata, 32'hFE208CE3);
    chk("beq_addr", imem_addr, 8'd4);
    cycle();
    chk("ww_after_5", words_written, 9'd5);

    // Illegal requests: accepted, not written, err sticky
    one_req(4, 1, 1, 0, 2048);
    chk("ill_addi_err", err, 1'b1);
    one_req(9, 0, 1, 2, 3);
    one_req(12, 1, 1, 1, 0);
    cycle();
    chk("ill_ww", words_written, 9'd5);
    chk("ill_we", imem_we, 1'b0);
    chk("ill_err_sticky", err, 1'b1);

    // Backpressure: six legal requests against a stalled memory
    ww0 = m_ww;
    for (int i = 0; i < 6; i++) begin
      bp_op[i]  = $urandom_range(0, 7);
      bp_imm[i] = int'($urandom_range(0, 4095)) - 2048;
    end
    imem_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      set_req(bp_op[idx], c + 1, c + 2, c + 3, bp_imm[idx]);
      in_valid = 1'b1;
      if (in_ready) idx++;
      cycle();
    end
    chk("bp_accepted", idx, 4);
    chk("bp_ready_low", in_ready, 1'b0);
    chk("bp_we_high", imem_we, 1'b1);
    imem_ready = 1'b1;
    n = 0;
    while ((idx < 6 || mq.size() > 0) && n < 50) begin
      if (idx < 6) set_req(bp_op[idx], idx + 1, idx + 2, idx + 3, bp_imm[idx]);
      in_valid = (idx < 6);
      if (idx < 6 && in_ready) idx++;
      cycle();
      n++;
    end
    in_valid = 1'b0;
    chk("bp_drain_timeout", n < 50, 1'b1);
    chk("bp_ww", words_written, 9'(ww0 + 6));

    // Reset mid-stream with three queued words
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) one_req(0, i + 1, 1, 2, 0);
    chk("pre_rst_err", err, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 8'd0);
    chk("rst_ww", words_written, 9'd0);
    chk("rst_err", err, 1'b0);
    imem_ready = 1'b1;
    one_req(0, 3, 1, 2, 0);
    chk("post_rst_addr", imem_addr, 8'd0);
    chk("post_rst_word", imem_wdata, 32'h002081B3);
    cycle();

    // Random traffic, then fill the 256-word space and keep pushing
    n = 0;
    while (!m_full && n < 4000) begin
      rand_req();
      in_valid   = ($urandom_range(0, 3) != 0);
      imem_ready = ($urandom_range(0, 4) != 0);
      cycle();
      n++;
    end
    chk("main_mem_full", mem_full, 1'b1);
    for (int c = 0; c < 30; c++) begin
      rand_req();
      in_valid   = 1'b1;
      imem_ready = $urandom_range(0, 1);
      cycle();
    end
    chk("main_full_ready", in_ready, 1'b0);
    in_valid = 1'b0;

    // Capacity on a four-word memory
    rst = 1'b1; imem_ready = 1'b1;
    cycle();
    rst = 1'b0;
    set_req(0, 3, 1, 2, 0);
    s_valid = 1'b1;
    repeat (4) cycle();
    s_valid = 1'b0;
    chk("s_full_pre", s_full, 1'b0);
    chk("s_ww_3", s_ww, 3'd3);
    chk("s_addr_3", s_addr, 2'd3);
    cycle();
    chk("s_full_set", s_full, 1'b1);
    chk("s_ww_4", s_ww, 3'd4);
    chk("s_we_full", s_we, 1'b0);
    s_valid = 1'b1;
    cycle();
    s_valid = 1'b0;
    chk("s_fifth_not_written", s_we, 1'b0);
    chk("s_ready_after5", s_in_ready, 1'b1);
    acc_cnt = 1;
    s_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (s_in_ready) acc_cnt++;
      cycle();
    end
    s_valid = 1'b0;
    chk("s_fifo_fill", acc_cnt, 4);
    chk("s_ready_low", s_in_ready, 1'b0);
    chk("s_ww_hold", s_ww, 3'd4);
    chk("s_err", s_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
